// File: rtl/chip7458_exerciser.sv
// Pattern sequencer for a dual AND-OR gate stage: drives 10 inputs, checks the two
// returned outputs against a golden model, and reports error count and first failure.
module chip7458_exerciser #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 11
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             pat_mode,
   output logic [9:0]       drv,
   input  logic             p1y_in,
   input  logic             p2y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [9:0]       first_err_vec,
   output logic             first_err_valid,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   state_t     state, state_next;
   logic [3:0] cnt;
   logic [9:0] idx;
   logic       mode;
   logic       exp_p1, exp_p2, mismatch;
   logic       last_vec, settle_end, accept;
   logic [9:0] next_vec;

   assign state_dbg  = state;
   assign exp_p1     = (drv[0] & drv[1] & drv[2]) | (drv[3] & drv[4] & drv[5]);
   assign exp_p2     = (drv[6] & drv[7]) | (drv[8] & drv[9]);
   assign mismatch   = (p1y_in != exp_p1) || (p2y_in != exp_p2);
   // The LFSR never produces zero, so its run is one vector shorter.
   assign last_vec   = mode ? (idx == 10'd1022) : (idx == 10'd1023);
   assign next_vec   = mode ? {drv[8:0], drv[9] ^ drv[6]} : drv + 10'd1;
   assign settle_end = (cnt == SETTLE_LAST);
   assign accept     = ((state == IDLE) || (state == DONE)) && start;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start)      state_next = SETTLE;
         SETTLE:     if (settle_end) state_next = CHECK;
         CHECK:      state_next = last_vec ? DONE : SETTLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drv             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
         cnt             <= '0;
         idx             <= '0;
         mode            <= 1'b0;
      end else if (accept) begin
         mode            <= pat_mode;
         drv             <= pat_mode ? 10'h001 : 10'h000;
         idx             <= '0;
         cnt             <= '0;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         busy            <= 1'b1;
      end else if (state == SETTLE) begin
         cnt <= cnt + 4'd1;
      end else if (state == CHECK) begin
         if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
            if (!first_err_valid) begin
               first_err_vec   <= drv;
               first_err_valid <= 1'b1;
            end
         end
         if (last_vec) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (err_cnt == '0) && !mismatch;
         end else begin
            drv <= next_vec;
            idx <= idx + 10'd1;
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_chip7458_exerciser.sv
// Directed bench for chip7458_exerciser: a behavioural gate stage with injectable
// stuck faults feeds the sequencer; each scenario task checks hand-computed results.
module tb_chip7458_exerciser;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        pat_mode;
   logic [9:0]  drv;
   logic        p1y_in, p2y_in;
   logic        busy, done, pass;
   logic [10:0] err_cnt;
   logic [9:0]  first_err_vec;
   logic        first_err_valid;
   logic [1:0]  state_dbg;

   int n_vec  = 0;
   int n_miss = 0;

   // 0 = good stage, 1 = p1y stuck at 0, 2 = p2y stuck at 1
   int fault = 0;

   int          cyc;
   logic [9:0]  drv_at0, drv_at3, drv_at6;
   logic        acc_busy, acc_done, acc_fvalid;
   logic [10:0] acc_err;

   chip7458_exerciser #(.SETTLE_CYCLES(2), .ERR_W(11)) dut (
      .clk(clk), .resetn(resetn), .start(start), .pat_mode(pat_mode),
      .drv(drv), .p1y_in(p1y_in), .p2y_in(p2y_in),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_vec(first_err_vec), .first_err_valid(first_err_valid),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      p1y_in = (drv[0] & drv[1] & drv[2]) | (drv[3] & drv[4] & drv[5]);
      p2y_in = (drv[6] & drv[7]) | (drv[8] & drv[9]);
      if (fault == 1) p1y_in = 1'b0;
      if (fault == 2) p2y_in = 1'b1;
   end

   // Pulses start, then counts edges after the accept edge until done (bounded).
   // If restart_at >= 0, start is raised again for one cycle at that count.
   task automatic run(input logic mode, input int restart_at);
      @(negedge clk);
      start    = 1'b1;
      pat_mode = mode;
      @(posedge clk);
      #1;
      start      = 1'b0;
      cyc        = 0;
      acc_busy   = busy;
      acc_done   = done;
      acc_err    = err_cnt;
      acc_fvalid = first_err_valid;
      drv_at0    = drv;
      while (!done && cyc < 5000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 3) drv_at3 = drv;
         if (cyc == 6) drv_at6 = drv;
         start    = (cyc == restart_at);
         pat_mode = (cyc == restart_at) ? ~mode : mode;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; pat_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (drv !== 10'h000) begin n_miss++; $display("FAIL reset_drv got %h want 000", drv); end
      n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b want 0", done); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL reset_pass got %b want 0", pass); end
      n_vec++; if (err_cnt !== 11'd0) begin n_miss++; $display("FAIL reset_err got %0d want 0", err_cnt); end
      n_vec++; if (first_err_valid !== 1'b0 || first_err_vec !== 10'h000) begin
         n_miss++; $display("FAIL reset_first got %b/%h want 0/000", first_err_valid, first_err_vec);
      end
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_exhaustive_good();
      fault = 0;
      run(1'b0, -1);
      n_vec++; if (acc_busy !== 1'b1) begin n_miss++; $display("FAIL exh_busy_at_accept got %b want 1", acc_busy); end
      n_vec++; if (drv_at0 !== 10'h000 || drv_at3 !== 10'h001) begin
         n_miss++; $display("FAIL exh_first_vecs got %h,%h want 000,001", drv_at0, drv_at3);
      end
      n_vec++; if (cyc !== 3072) begin n_miss++; $display("FAIL exh_done_time got %0d want 3072", cyc); end
      n_vec++; if (err_cnt !== 11'd0 || pass !== 1'b1) begin
         n_miss++; $display("FAIL exh_result got err=%0d pass=%b want err=0 pass=1", err_cnt, pass);
      end
      n_vec++; if (first_err_valid !== 1'b0) begin n_miss++; $display("FAIL exh_fvalid got %b want 0", first_err_valid); end
      n_vec++; if (drv !== 10'h3FF || busy !== 1'b0) begin
         n_miss++; $display("FAIL exh_final got drv=%h busy=%b want 3FF/0", drv, busy);
      end
   endtask

   task automatic test_p1_stuck0();
      fault = 1;
      run(1'b0, -1);
      n_vec++; if (err_cnt !== 11'd240) begin n_miss++; $display("FAIL p1s0_err got %0d want 240", err_cnt); end
      n_vec++; if (pass !== 1'b0) begin n_miss++; $display("FAIL p1s0_pass got %b want 0", pass); end
      n_vec++; if (first_err_vec !== 10'h007 || first_err_valid !== 1'b1) begin
         n_miss++; $display("FAIL p1s0_first got %h/%b want 007/1", first_err_vec, first_err_valid);
      end
   endtask

   // Also a start-in-DONE case: counters from the previous faulty run must clear.
   task automatic test_p2_stuck1();
      fault = 2;
      run(1'b0, -1);
      n_vec++; if (acc_done !== 1'b0 || acc_err !== 11'd0 || acc_fvalid !== 1'b0) begin
         n_miss++; $display("FAIL restart_clear got done=%b err=%0d fv=%b want 0/0/0", acc_done, acc_err, acc_fvalid);
      end
      n_vec++; if (err_cnt !== 11'd576) begin n_miss++; $display("FAIL p2s1_err got %0d want 576", err_cnt); end
      n_vec++; if (first_err_vec !== 10'h000 || first_err_valid !== 1'b1) begin
         n_miss++; $display("FAIL p2s1_first got %h/%b want 000/1", first_err_vec, first_err_valid);
      end
      n_vec++; if (cyc !== 3072) begin n_miss++; $display("FAIL p2s1_done_time got %0d want 3072", cyc); end
   endtask

   task automatic test_lfsr_good();
      fault = 0;
      run(1'b1, -1);
      n_vec++; if (drv_at0 !== 10'h001 || drv_at3 !== 10'h002 || drv_at6 !== 10'h004) begin
         n_miss++; $display("FAIL lfsr_seq got %h,%h,%h want 001,002,004", drv_at0, drv_at3, drv_at6);
      end
      n_vec++; if (cyc !== 3069) begin n_miss++; $display("FAIL lfsr_done_time got %0d want 3069", cyc); end
      n_vec++; if (err_cnt !== 11'd0 || pass !== 1'b1) begin
         n_miss++; $display("FAIL lfsr_result got err=%0d pass=%b want 0/1", err_cnt, pass);
      end
      // The vector preceding the seed in the cycle is 10'h200.
      n_vec++; if (drv !== 10'h200) begin n_miss++; $display("FAIL lfsr_last got %h want 200", drv); end
   endtask

   task automatic test_start_while_busy();
      fault = 0;
      run(1'b0, 100);
      n_vec++; if (cyc !== 3072) begin n_miss++; $display("FAIL busy_start_time got %0d want 3072", cyc); end
      n_vec++; if (drv !== 10'h3FF || pass !== 1'b1) begin
         n_miss++; $display("FAIL busy_start_final got drv=%h pass=%b want 3FF/1", drv, pass);
      end
   endtask

   task automatic test_abort();
      fault = 1;
      @(negedge clk);
      start = 1'b1; pat_mode = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b1 || err_cnt === 11'd0) begin
         n_miss++; $display("FAIL abort_pre got busy=%b err=%0d want 1/nonzero", busy, err_cnt);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_vec++; if (drv !== 10'h000 || busy !== 1'b0 || err_cnt !== 11'd0) begin
         n_miss++; $display("FAIL abort_async got drv=%h busy=%b err=%0d want 000/0/0", drv, busy, err_cnt);
      end
      n_vec++; if (first_err_valid !== 1'b0 || done !== 1'b0) begin
         n_miss++; $display("FAIL abort_flags got fv=%b done=%b want 0/0", first_err_valid, done);
      end
      @(negedge clk);
      resetn = 1'b1;
      fault  = 0;
      repeat (2) @(posedge clk);
      run(1'b0, -1);
      n_vec++; if (cyc !== 3072 || err_cnt !== 11'd0 || pass !== 1'b1) begin
         n_miss++; $display("FAIL abort_rerun got cyc=%0d err=%0d pass=%b want 3072/0/1", cyc, err_cnt, pass);
      end
   endtask

   initial begin
      test_reset();
      test_exhaustive_good();
      test_p1_stuck0();
      test_p2_stuck1();
      test_lfsr_good();
      test_start_while_busy();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
